// File: rtl/four_digit_led_driver.sv
// rtl/four_digit_led_driver.sv - time-multiplexed 4-digit common-anode 7-segment driver
//
// Purpose: scans a fixed 4-digit hex MESSAGE across a common-anode display,
//   one digit at a time. Each digit slot has 4 phases: 2 lit, 2 blank guard.
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous, active-high; display dark while asserted
//   an3..an0       active-low anodes (an3 = leftmost digit)
//   a..g           active-low segments
//   dp             decimal point, held off (1)
module four_digit_led_driver #(
  parameter int unsigned PRESCALE = 1,
  parameter logic [15:0] MESSAGE  = 16'h0123
) (
  input  logic clk,
  input  logic reset,
  output logic an3,
  output logic an2,
  output logic an1,
  output logic an0,
  output logic a,
  output logic b,
  output logic c,
  output logic d,
  output logic e,
  output logic f,
  output logic g,
  output logic dp
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [6:0]    seg_q, seg_d;
  logic          tick;
  logic [3:0]    digit;
  logic          lit_phase;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  always_comb begin
    tick  = (pre_q == PRE_LAST);
    pre_d = tick ? '0 : pre_q + 1'b1;

    // Digit for the slot the counter is in before this tick; loading on the
    // slot's first phase keeps seg_q stable while that slot's anode is low.
    case (cnt_q[3:2])
      2'd3:    digit = MESSAGE[15:12];
      2'd2:    digit = MESSAGE[11:8];
      2'd1:    digit = MESSAGE[7:4];
      default: digit = MESSAGE[3:0];
    endcase

    cnt_d = cnt_q;
    seg_d = seg_q;
    if (tick) begin
      cnt_d = cnt_q - 4'd1;   // 0 wraps to 15: continuous 16-phase frame
      seg_d = decode(digit);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q <= '0;
      cnt_q <= 4'hF;
      seg_q <= 7'b1111111;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
      seg_q <= seg_d;
    end
  end

  // Phases 2'b10 and 2'b01 are lit; 2'b11 and 2'b00 are guard phases.
  assign lit_phase = cnt_q[1] ^ cnt_q[0];

  assign an3 = ~(lit_phase && (cnt_q[3:2] == 2'd3));
  assign an2 = ~(lit_phase && (cnt_q[3:2] == 2'd2));
  assign an1 = ~(lit_phase && (cnt_q[3:2] == 2'd1));
  assign an0 = ~(lit_phase && (cnt_q[3:2] == 2'd0));

  assign {a, b, c, d, e, f, g} = seg_q;
  assign dp = 1'b1;

endmodule

// File: tb/tb_four_digit_led_driver.sv
// tb/tb_four_digit_led_driver.sv - directed table-driven bench for four_digit_led_driver
module tb_four_digit_led_driver;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
  } frame_vec_t;

  typedef struct {
    int         k;
    logic [3:0] an;
    logic [6:0] seg;
  } p4_vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  // Main instance: PRESCALE=1, MESSAGE=0123
  wire [3:0] m_an;
  wire [6:0] m_seg;
  wire       m_dp;

  four_digit_led_driver #(.PRESCALE(1), .MESSAGE(16'h0123)) dut (
    .clk(clk), .reset(reset),
    .an3(m_an[3]), .an2(m_an[2]), .an1(m_an[1]), .an0(m_an[0]),
    .a(m_seg[6]), .b(m_seg[5]), .c(m_seg[4]), .d(m_seg[3]),
    .e(m_seg[2]), .f(m_seg[1]), .g(m_seg[0]), .dp(m_dp)
  );

  // Prescaled instance: PRESCALE=4, MESSAGE=ABCF
  wire [3:0] p_an;
  wire [6:0] p_seg;
  wire       p_dp;

  four_digit_led_driver #(.PRESCALE(4), .MESSAGE(16'hABCF)) dut_p4 (
    .clk(clk), .reset(reset),
    .an3(p_an[3]), .an2(p_an[2]), .an1(p_an[1]), .an0(p_an[0]),
    .a(p_seg[6]), .b(p_seg[5]), .c(p_seg[4]), .d(p_seg[3]),
    .e(p_seg[2]), .f(p_seg[1]), .g(p_seg[0]), .dp(p_dp)
  );

  // Sweep instances: digit3 = 0..F
  wire [3:0] sw_an  [16];
  wire [6:0] sw_seg [16];

  for (genvar gd = 0; gd < 16; gd++) begin : g_sweep
    wire [3:0] l_an;
    wire [6:0] l_seg;
    wire       l_dp;
    four_digit_led_driver #(.PRESCALE(1), .MESSAGE(16'((gd << 12) | 16'h0123))) dut_sw (
      .clk(clk), .reset(reset),
      .an3(l_an[3]), .an2(l_an[2]), .an1(l_an[1]), .an0(l_an[0]),
      .a(l_seg[6]), .b(l_seg[5]), .c(l_seg[4]), .d(l_seg[3]),
      .e(l_seg[2]), .f(l_seg[1]), .g(l_seg[0]), .dp(l_dp)
    );
    assign sw_an[gd]  = l_an;
    assign sw_seg[gd] = l_seg;
  end

  logic [6:0] dec_tab [16];
  frame_vec_t frame_tab [16];
  p4_vec_t    p4_tab [14];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_dark(input string tag);
    check({tag, "_an"},  8'(m_an),  8'h0F);
    check({tag, "_seg"}, 8'(m_seg), 8'h7F);
    check({tag, "_dp"},  8'(m_dp),  8'h01);
  endtask

  task automatic check_frame(input string tag, input int idx);
    check($sformatf("%s_an[%0d]", tag, idx),  8'(m_an),  8'(frame_tab[idx % 16].an));
    check($sformatf("%s_seg[%0d]", tag, idx), 8'(m_seg), 8'(frame_tab[idx % 16].seg));
  endtask

  initial begin
    dec_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    // Edge n after reset release -> frame_tab[n-1], MESSAGE=0123
    frame_tab = '{
      '{4'b0111, 7'b0000001}, '{4'b0111, 7'b0000001},
      '{4'b1111, 7'b0000001}, '{4'b1111, 7'b0000001},
      '{4'b1011, 7'b1001111}, '{4'b1011, 7'b1001111},
      '{4'b1111, 7'b1001111}, '{4'b1111, 7'b1001111},
      '{4'b1101, 7'b0010010}, '{4'b1101, 7'b0010010},
      '{4'b1111, 7'b0010010}, '{4'b1111, 7'b0010010},
      '{4'b1110, 7'b0000110}, '{4'b1110, 7'b0000110},
      '{4'b1111, 7'b0000110}, '{4'b1111, 7'b0000110}
    };

    // PRESCALE=4, MESSAGE=ABCF checkpoints: edge k after release
    p4_tab = '{
      '{1,  4'b1111, 7'b1111111}, '{3,  4'b1111, 7'b1111111},
      '{4,  4'b0111, 7'b0001000}, '{7,  4'b0111, 7'b0001000},
      '{8,  4'b0111, 7'b0001000}, '{11, 4'b0111, 7'b0001000},
      '{12, 4'b1111, 7'b0001000}, '{20, 4'b1011, 7'b1100000},
      '{23, 4'b1011, 7'b1100000}, '{24, 4'b1011, 7'b1100000},
      '{36, 4'b1101, 7'b0110001}, '{52, 4'b1110, 7'b0111000},
      '{64, 4'b1111, 7'b0111000}, '{68, 4'b0111, 7'b0001000}
    };

    // Reset held for 20 clocks: dark throughout
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check_dark($sformatf("rst1_%0d", i));
    end
    check("rst1_p4_an", 8'(p_an), 8'h0F);
    check("rst1_sw_an", 8'(sw_an[5]), 8'h0F);

    // Release: 3 frames plus 6 edges, leaving cnt at 9
    reset = 1'b0;
    for (int k = 0; k < 54; k++) begin
      step();
      check_frame("run", k);
      check($sformatf("onehot[%0d]", k), 8'($countones(~m_an) <= 1), 8'h01);
      check($sformatf("dp[%0d]", k), 8'(m_dp), 8'h01);
    end

    // Mid-frame reset for 20 clocks
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check_dark($sformatf("rst2_%0d", i));
    end

    // Restart: main replays the table, sweep and prescaled instances checked
    reset = 1'b0;
    for (int k = 1; k <= 68; k++) begin
      step();
      check_frame("restart", k - 1);
      if (k <= 2) begin
        for (int dv = 0; dv < 16; dv++) begin
          check($sformatf("sweep_an[%0d,%0d]", dv, k),  8'(sw_an[dv]),  8'h07);
          check($sformatf("sweep_seg[%0d,%0d]", dv, k), 8'(sw_seg[dv]), 8'(dec_tab[dv]));
        end
      end
      for (int j = 0; j < 14; j++) begin
        if (p4_tab[j].k == k) begin
          check($sformatf("p4_an[%0d]", k),  8'(p_an),  8'(p4_tab[j].an));
          check($sformatf("p4_seg[%0d]", k), 8'(p_seg), 8'(p4_tab[j].seg));
          check($sformatf("p4_dp[%0d]", k),  8'(p_dp),  8'h01);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
